muldiv_sequencer: RTL and testbench

- Iterative multiply/divide unit with its own sequencing FSM and the architectural HI/LO registers.
- Sits beside the EX-stage ALU of the pipelined MIPS core. It executes mult/multu/div/divu over WIDTH+2 cycles and services mfhi/mflo/mthi/mtlo.
- Raises a stall request to the hazard unit whenever the ID-stage instruction touches HI/LO while an operation is in flight.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/muldiv_sequencer_if.sv | 41 ++++
 rtl/muldiv_datapath.sv | 76 +++++++
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit of the MIPS core.
//   - MD_* : op encodings presented on the op port alongside start.
//   - md_state_t : sequencer states (IDLE, RUN, FIX).
//   - md_is_div / md_is_signed : op decode helpers.
package mips_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Bundle between the EX/ID stages and the multiply/divide unit.
//   master : pipeline side (drives start/op/a/b, mthi/mtlo strobes, flush,
//            hilo_use_id; reads hi/lo/busy/done/stall/state).
//   slave  : muldiv_sequencer.
// Issue protocol: start is a request that the unit accepts only on an edge
// where it is idle (busy=0) and flush is low; there is no separate ready,
// because stall=busy&(start|hilo_use_id|hi_we|lo_we) tells the hazard unit to
// hold any HI/LO-touching instruction until busy falls. done is a one-cycle
// pulse on the cycle HI/LO first show a completed result. state is a debug
// view of the sequencer FSM.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);

  logic                  start;
  logic [1:0]            op;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic                  hi_we;
  logic                  lo_we;
  logic [WIDTH-1:0]      wdata;
  logic                  hilo_use_id;
  logic                  flush;
  logic [WIDTH-1:0]      hi;
  logic [WIDTH-1:0]      lo;
  logic                  busy;
  logic                  done;
  logic                  stall;
  mips_pkg::md_state_t   state;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata, hilo_use_id, flush,
    input  hi, lo, busy, done, stall, state
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata, hilo_use_id, flush,
    output hi, lo, busy, done, stall, state
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Iterative unsigned multiply / restoring-divide engine.
//   clk, reset : core clock, async active-high reset.
//   load       : capture magnitudes, clear accumulator and counter.
//   step       : perform one iteration (one bit).
//   is_div     : selects restoring divide instead of shift-add multiply.
//   mag_a/mag_b: unsigned operand magnitudes (sampled on load).
//   acc        : 2*WIDTH result; multiply -> product,
//                divide -> {remainder, quotient}.
//   last       : the current step is the final (WIDTH-th) iteration.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH + 1);

  // opnd: multiplicand (mult) or divisor (div), held for the whole op.
  // shreg: multiplier consumed LSB first, or dividend consumed MSB first.
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   shreg;
  logic [CW-1:0]      count;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Multiply: add into the upper half, then shift the whole product right
    // so the carry lands in the top bit.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (shreg[0] ? opnd : '0)};
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: bring the next dividend bit into the partial remainder. The
    // remainder always stays below the divisor, so WIDTH bits suffice after
    // the trial subtract/restore. A zero divisor makes every trial succeed.
    trial    = {acc[2*WIDTH-1:WIDTH], shreg[WIDTH-1]};
    diff     = trial - {1'b0, opnd};
    ge       = (trial >= {1'b0, opnd});
    rem_next = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    div_next = {rem_next, acc[WIDTH-2:0], ge};

    last     = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd  <= '0;
      shreg <= '0;
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      opnd  <= is_div ? mag_b : mag_a;
      shreg <= is_div ? mag_a : mag_b;
      acc   <= '0;
      count <= '0;
    end else if (step) begin
      shreg <= is_div ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      acc   <= is_div ? div_next : mul_next;
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide unit beside the EX-stage ALU: sequencing FSM, sign
// handling, architectural HI/LO registers and the HI/LO hazard stall.
//   clk, reset : core clock, async active-high reset.
//   bus        : muldiv_sequencer_if slave (issue, mthi/mtlo, flush,
//                hilo_use_id in; hi, lo, busy, done, stall, state out).
// An accepted start runs WIDTH iterations in RUN and a sign-fix/write cycle
// in FIX, so HI/LO and done appear after the (WIDTH+1)-th edge past issue.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_sequencer_if.slave bus
);

  import mips_pkg::*;

  md_state_t          state;
  md_state_t          state_next;

  logic               div_q;    // operation is a divide
  logic               neg_q;    // operand signs differ (product/quotient negate)
  logic               rsign_q;  // dividend negative (remainder sign)
  logic               dz_q;     // divide by zero seen at issue
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               accept;
  logic               dp_load;
  logic               dp_step;
  logic               write_res;
  logic [2*WIDTH-1:0] acc;
  logic               last;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Magnitudes: the most negative value maps onto itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    a_neg  = md_is_signed(bus.op) & bus.a[WIDTH-1];
    b_neg  = md_is_signed(bus.op) & bus.b[WIDTH-1];
    mag_a  = a_neg ? -bus.a : bus.a;
    mag_b  = b_neg ? -bus.b : bus.b;
    // flush squashes a same-cycle issue.
    accept = (state == IDLE) & bus.start & ~bus.flush;
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (dp_load),
    .step   (dp_step),
    .is_div (accept ? md_is_div(bus.op) : div_q),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .acc    (acc),
    .last   (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    write_res  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          dp_load    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else begin
          dp_step = 1'b1;
          if (last) state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        write_res  = ~bus.flush;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sign correction of the unsigned engine result.
  always_comb begin
    prod = neg_q   ? -acc : acc;
    quot = neg_q   ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = rsign_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (div_q) begin
      // With a zero divisor the remainder path reproduces the dividend, so
      // HI=a falls out naturally; only LO needs forcing.
      res_hi = rem;
      res_lo = dz_q ? '1 : quot;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= write_res;
      if (accept) begin
        div_q   <= md_is_div(bus.op);
        neg_q   <= a_neg ^ b_neg;
        rsign_q <= a_neg;
        dz_q    <= md_is_div(bus.op) & (bus.b == '0);
      end
      // mthi/mtlo only land while idle; while busy the stall makes the
      // pipeline re-present them.
      if (write_res) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state == IDLE) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state != IDLE);
  assign bus.stall = (state != IDLE) &
                     (bus.hilo_use_id | bus.start | bus.hi_we | bus.lo_we);
  assign bus.state = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases for latency,
// sign rules, divide by zero, overflow, stall, flush and async reset, then
// randomized ops against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic clk;
  logic reset;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural result of one op, from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] mhi, output logic [W-1:0] mlo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mhi = '0;
    mlo = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; mhi = p[63:32]; mlo = p[31:0]; end
      2'b10: begin
        if (b == '0) begin mhi = a; mlo = '1; end
        else begin
          q = sa / sb;  // truncates toward zero
          r = sa % sb;  // takes the dividend's sign
          mlo = q[31:0];
          mhi = r[31:0];
        end
      end
      default: begin
        if (b == '0) begin mhi = a; mlo = '1; end
        else begin mlo = a / b; mhi = a % b; end
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // All driving and sampling happens at the falling edge.
  task automatic write_hilo(input logic hw, input logic lw, input logic [W-1:0] d);
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wdata = d;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    if (hw) exp_hi = d;
    if (lw) exp_lo = d;
    check("mt_hi", bus.hi, exp_hi);
    check("mt_lo", bus.lo, exp_lo);
  endtask

  // Issue one op and wait for completion; with_mt also writes HI at the
  // issue edge, which must be visible until the result overwrites it.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic with_mt);
    int lat;
    logic [W-1:0] mh, ml;
    model(op, a, b, mh, ml);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (with_mt) begin
      bus.hi_we = 1'b1;
      bus.wdata = 32'hCAFE_0001;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check("busy_after_issue", bus.busy, 1);
    if (with_mt) check("mthi_with_start", bus.hi, 32'hCAFE_0001);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    exp_hi = mh;
    exp_lo = ml;
    check("latency", lat, 34);
    check("res_hi", bus.hi, exp_hi);
    check("res_lo", bus.lo, exp_lo);
    check("busy_at_done", bus.busy, 0);
    @(negedge clk);
    check("done_pulse_width", bus.done, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 15));
      6: return -W'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int done_seen;
    logic [1:0] rop;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    bus.hilo_use_id = 0; bus.flush = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    reset = 1'b0;
    @(negedge clk);
    bus.hilo_use_id = 1'b1;
    #1 check("idle_no_stall", bus.stall, 0);
    bus.hilo_use_id = 1'b0;

    // Directed arithmetic cases.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("tp_multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("tp_multu_lo", bus.lo, 32'h0000_0001);
    run_op(2'b00, -32'sd3, 32'd7, 1'b0);
    check("tp_mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("tp_mult_lo", bus.lo, 32'hFFFF_FFEB);
    run_op(2'b10, -32'sd7, 32'd2, 1'b0);
    check("tp_div_lo", bus.lo, 32'hFFFF_FFFD);
    check("tp_div_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd0, 1'b0);
    check("tp_divu0_hi", bus.hi, 32'h0000_0064);
    check("tp_divu0_lo", bus.lo, 32'hFFFF_FFFF);
    run_op(2'b10, -32'sd100, 32'd0, 1'b0);
    check("tp_div0_hi", bus.hi, 32'hFFFF_FF9C);
    check("tp_div0_lo", bus.lo, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("tp_ovf_lo", bus.lo, 32'h8000_0000);
    check("tp_ovf_hi", bus.hi, 32'h0000_0000);

    // mthi then mult with an mflo waiting in ID from the fifth edge.
    write_hilo(1'b1, 1'b0, 32'h0000_1234);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (n < 5) begin @(negedge clk); n++; end
    bus.hilo_use_id = 1'b1;
    #1 check("stall_on_use", bus.stall, 1);
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done !== 1'b1) check("stall_held", bus.stall, 1);
    end
    check("stall_latency", n, 34);
    check("stall_released", bus.stall, 0);
    check("stall_lo", bus.lo, 32'd6);
    check("stall_hi", bus.hi, 32'd0);
    exp_hi = 0; exp_lo = 6;
    bus.hilo_use_id = 1'b0;

    // Flush mid-divide; mthi/mtlo and a second start while busy are dropped.
    write_hilo(1'b1, 1'b1, 32'h0000_00AA);
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    done_seen = 0;
    while (n < 10) begin
      if (n == 5) begin
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5555_5555;
        #1 check("stall_on_mt", bus.stall, 1);
      end
      @(negedge clk);
      n++;
    end
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.flush = 1'b1;
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9;
    #1 check("stall_on_start", bus.stall, 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("flush_no_done", done_seen, 0);
    check("flush_busy_late", bus.busy, 0);
    check("flush_hi", bus.hi, 32'h0000_00AA);
    check("flush_lo", bus.lo, 32'h0000_00AA);
    exp_hi = 32'hAA; exp_lo = 32'hAA;
    // flush and start together while idle: nothing starts.
    bus.flush = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    check("flush_start_idle", bus.busy, 0);

    // Async reset in the middle of a multiply.
    write_hilo(1'b1, 1'b1, 32'hDEAD_BEEF);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h0001_2345; bus.b = 32'h0000_0777;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (n < 20) begin @(negedge clk); n++; end
    #2 reset = 1'b1;
    #1;
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    check("arst_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = 0; exp_lo = 0;
    @(negedge clk);
    run_op(2'b00, 32'h0001_2345, 32'h0000_0777, 1'b0);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      run_op(rop, pick(), pick(), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
